spi_config_rx: RTL and testbench
================================

Name: spi_config_rx

Overview:
SPI responder, the receiving end of the codec-style 16-bit register-write frames our configurator issues. An external controller (MCU or a second board) uses it to write effect parameters into the FPGA: echo enable, delay length, gains. The block oversamples SCLK/MOSI/CS in the system clock domain, deserialises each frame and updates a small 9-bit register file. It also emits a one-cycle write strobe.

Parameters:
NUM_REGS, 16, number of 9-bit registers implemented (addresses 0..NUM_REGS-1; max 128)
FRAME_BITS, 16, bits per frame: 7-bit address followed by 9-bit data

Ports:
clk  input  1  system clock; must be >= 4x the SCLK frequency
reset  input  1  synchronous, active-high reset
spi_sck  input  1  SPI clock from controller, mode 0 (idle low, sample on rising edge)
spi_mosi  input  1  serial data, MSB first
cs  input  1  active-low chip select; frame boundary
spi_miso  output  1  readback data (see Optional Feature); 0 when the feature is compiled out
regs  output  NUM_REGS*9  flattened register file; reg n occupies bits [9n+8:9n]
wr_valid  output  1  one-cycle pulse when a register is written
wr_addr  output  7  address of the last accepted frame
wr_data  output  9  data of the last accepted frame
frame_err  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Input sync: spi_sck, spi_mosi and cs each pass through a 2-FF synchroniser. A third register on sck and cs provides edge detection.
- Reset outputs: regs all 0, wr_valid 0, wr_addr 0, wr_data 0, frame_err 0, spi_miso 0. Shift register, bit counter and armed flag are cleared. FSM goes to WAIT_IDLE.
- FSM WAIT_IDLE: ignore traffic until synced cs is high, then go to IDLE. This prevents accepting a partial frame when leaving reset mid-transfer.
- FSM IDLE: on synced cs falling, clear shift register and bit counter, then go to SHIFT.
- FSM SHIFT:
  - on each sck rising edge while cs low: shift = {shift[14:0], mosi_sync}; bitcnt increments, saturating at 31.
  - on synced cs rising: go to COMMIT.
- FSM COMMIT (1 cycle), then go to IDLE:
  - if bitcnt == FRAME_BITS and addr = shift[15:9] < NUM_REGS: regs[addr] <= shift[8:0]; wr_addr/wr_data updated; wr_valid = 1 for this cycle.
  - if bitcnt != FRAME_BITS (short, long or empty frame): no write; frame_err = 1 for one cycle.
  - if addr >= NUM_REGS: no write; frame_err = 1 for one cycle.
- Latency: wr_valid rises exactly 4 clk cycles after the cs pin rising edge (2 sync + 1 edge register + COMMIT). regs changes in the same cycle wr_valid is high.
- sck edges while cs is high are ignored.
- cs glitch of 0 bits (low then high with no sck edge) produces frame_err.
- Back-to-back frames: cs may fall again as soon as 2 clk after rising; COMMIT completes before IDLE samples cs.
- reset asserted mid-frame: frame is discarded, FSM returns to WAIT_IDLE, no wr_valid.

Optional Feature:
SPI_READBACK_EN:
- Defined: during a frame, spi_miso shifts out the current content of the register addressed by the previous accepted frame, as 16 bits {wr_addr, regs[wr_addr]}, MSB first.
  - First bit is driven when cs falls; each following bit updates on a synced sck falling edge.
  - Output is registered and holds 0 while cs is high.
- Undefined: spi_miso is constant 0 and no readback shift logic is generated.

Decomposition:
- Shared package/include: FRAME_BITS, ADDR_BITS = 7, DATA_BITS = 9, FSM state encodings (WAIT_IDLE, IDLE, SHIFT, COMMIT), register index constants (REG_ECHO_EN = 0, REG_DELAY = 1, REG_GAIN = 2).
- One sub-module: sync_edge. It is a 2-FF synchroniser plus rise/fall pulse outputs, instantiated once each for spi_sck and cs. mosi uses the synchroniser only.

Test Plan:
- Reset, then frame 0x0355 (addr 1, data 0x155) at SCLK = clk/8 -> wr_valid one pulse 4 clk after cs rise; wr_addr = 1, wr_data = 0x155, regs[1] = 0x155, all other regs 0.
- 15-bit frame, then 17-bit frame -> frame_err pulses twice; regs unchanged; wr_valid never asserted.
- Frame to addr 20 (0x2801) with NUM_REGS = 16 -> frame_err pulse, no write.
- Hold cs low through reset release, clock 8 bits, raise cs -> no wr_valid, no frame_err. The next full frame 0x0001 writes regs[0] = 1.
- Two back-to-back frames 0x0010 / 0x0411 with a 2-clk cs high gap -> two wr_valid pulses; regs[0] = 0x010, regs[2] = 0x011.
- With SPI_READBACK_EN: write 0x0355, then clock a dummy frame -> spi_miso reads 0x0355 MSB first.

Source files
------------

// File: rtl/spi_config_rx_pkg.sv
// Shared constants and FSM encoding for the SPI register-write responder.
package spi_config_rx_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 9;
    localparam int CNT_BITS   = 5;

    localparam int REG_ECHO_EN = 0;
    localparam int REG_DELAY   = 1;
    localparam int REG_GAIN    = 2;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

endpackage

// File: rtl/spi_config_rx_sync_edge.sv
// Two-flop synchroniser with a third stage for single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s_p0, s_p1, s_p2;

    // Cleared to 0 so a chip select held low through reset never looks idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_p0 <= 1'b0;
            s_p1 <= 1'b0;
            s_p2 <= 1'b0;
        end else begin
            s_p0 <= d;
            s_p1 <= s_p0;
            s_p2 <= s_p1;
        end
    end

    assign q    = s_p1;
    assign rise = s_p1 & ~s_p2;
    assign fall = ~s_p1 & s_p2;

endmodule

// File: rtl/spi_config_rx.sv
// SPI mode-0 responder writing 16-bit {addr, data} frames into a 9-bit register file.
// Optional readback on spi_miso is built when SPI_READBACK_EN is defined.
module spi_config_rx #(
    parameter int NUM_REGS   = 16,
    parameter int FRAME_BITS = spi_config_rx_pkg::FRAME_BITS
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       spi_sck,
    input  logic                                       spi_mosi,
    input  logic                                       cs,
    output logic                                       spi_miso,
    output logic [NUM_REGS*spi_config_rx_pkg::DATA_BITS-1:0] regs,
    output logic                                       wr_valid,
    output logic [spi_config_rx_pkg::ADDR_BITS-1:0]    wr_addr,
    output logic [spi_config_rx_pkg::DATA_BITS-1:0]    wr_data,
    output logic                                       frame_err
);

    import spi_config_rx_pkg::*;

    logic sck_rise, sck_fall, sck_q_unused;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_p0, mosi_p1;

    state_t state, state_nxt;
    logic [FRAME_BITS-1:0] shift;
    logic [CNT_BITS-1:0]   bitcnt;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_BITS-1:0]  data;
    logic                  len_ok, addr_ok;

    sync_edge u_sck (.clk(clk), .reset(reset), .d(spi_sck), .q(sck_q_unused),
                     .rise(sck_rise), .fall(sck_fall));
    sync_edge u_cs  (.clk(clk), .reset(reset), .d(cs), .q(cs_q),
                     .rise(cs_rise), .fall(cs_fall));

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign addr    = shift[FRAME_BITS-1 -: ADDR_BITS];
    assign data    = shift[DATA_BITS-1:0];
    assign len_ok  = (bitcnt == CNT_BITS'(FRAME_BITS));
    assign addr_ok = ({1'b0, addr} < 8'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (cs_q)    state_nxt = IDLE;
            IDLE:      if (cs_fall) state_nxt = SHIFT;
            SHIFT:     if (cs_rise) state_nxt = COMMIT;
            COMMIT:                 state_nxt = IDLE;
            default:                state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift     <= '0;
            bitcnt    <= '0;
            regs      <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shift  <= '0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sck_rise && !cs_q) begin
                        shift <= {shift[FRAME_BITS-2:0], mosi_p1};
                        if (bitcnt != '1) bitcnt <= bitcnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (len_ok && addr_ok) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (int'(addr) == i) regs[i*DATA_BITS +: DATA_BITS] <= data;
                        wr_addr  <= addr;
                        wr_data  <= data;
                        wr_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    localparam int RB_BITS = ADDR_BITS + DATA_BITS;

    logic [RB_BITS-1:0]   rb;
    logic [DATA_BITS-1:0] rd_val;
    logic                 miso_r;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(wr_addr) == i) rd_val = regs[i*DATA_BITS +: DATA_BITS];
    end

    // Current output bit is kept at rb's MSB; shift on each synced sck fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb     <= '0;
            miso_r <= 1'b0;
        end else if (state == IDLE && cs_fall) begin
            rb     <= {wr_addr, rd_val};
            miso_r <= wr_addr[ADDR_BITS-1];
        end else if (cs_q) begin
            miso_r <= 1'b0;
        end else if (sck_fall) begin
            rb     <= {rb[RB_BITS-2:0], 1'b0};
            miso_r <= rb[RB_BITS-2];
        end
    end

    assign spi_miso = miso_r;
`else
    logic sck_fall_unused;
    assign sck_fall_unused = sck_fall;
    assign spi_miso        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_config_rx.sv
// Randomised self-checking bench for spi_config_rx against a frame-level register model.
module tb_spi_config_rx;

    localparam int NR = 16;

    logic clk = 1'b0;
    logic reset, spi_sck, spi_mosi, cs;
    logic spi_miso, wr_valid, frame_err;
    logic [NR*9-1:0] regs;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;

    spi_config_rx #(.NUM_REGS(NR), .FRAME_BITS(16)) dut (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .cs(cs),
        .spi_miso(spi_miso), .regs(regs), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, vld_cnt = 0, err_cnt = 0, vld_cyc = 0, rise_cyc = 0;
    logic [8:0]  model [NR];
    logic [15:0] rx_word;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_valid) begin
            vld_cnt++;
            vld_cyc = cyc;
        end
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++)
            chk($sformatf("reg%0d", i), 32'(regs[i*9 +: 9]), 32'(model[i]));
    endtask

    // SCLK = clk/8; MISO captured just before each rising edge like a controller would.
    task automatic clock_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            ticks(4);
            rx_word = {rx_word[14:0], spi_miso};
            spi_sck = 1'b1;
            ticks(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input int gap);
        cs = 1'b0;
        rx_word = '0;
        ticks(4);
        clock_bits(bits, n);
        ticks(4);
        cs = 1'b1;
        rise_cyc = cyc;
        ticks(gap);
    endtask

    task automatic check_frame(input logic [31:0] bits, input int n, input int v0, input int e0);
        logic [6:0] a;
        logic [8:0] d;
        logic       ok;
        a  = bits[15:9];
        d  = bits[8:0];
        ok = (n == 16) && (int'(a) < NR);
        chk("wr_valid_count", 32'(vld_cnt - v0), ok ? 32'd1 : 32'd0);
        chk("frame_err_count", 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
        if (ok) begin
            model[a] = d;
            chk("latency", 32'(vld_cyc - rise_cyc), 32'd4);
            chk("wr_addr", 32'(wr_addr), 32'(a));
            chk("wr_data", 32'(wr_data), 32'(d));
        end
        check_regs();
    endtask

    task automatic do_frame(input logic [31:0] bits, input int n);
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        frame(bits, n, 12);
        check_frame(bits, n, v0, e0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        clear_model();
        ticks(3);
    endtask

    initial begin
        int v0, e0, n;
        logic [31:0] bits;

        reset = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; cs = 1'b1;
        apply_reset();
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        check_regs();

        do_frame(32'h0355, 16);
`ifndef SPI_READBACK_EN
        chk("miso_off", 32'(rx_word), 32'd0);
`endif
        do_frame(32'h2AAA >> 1, 15);
        do_frame(32'h1_5A5A, 17);
        do_frame(32'h2801, 16);
        do_frame(32'h0, 0);

        // Chip select held low across reset release: the partial frame must vanish.
        cs = 1'b0;
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        clear_model();
        ticks(3);
        v0 = vld_cnt;
        e0 = err_cnt;
        clock_bits(32'hA5, 8);
        ticks(4);
        cs = 1'b1;
        ticks(12);
        chk("midreset_vld", 32'(vld_cnt - v0), 32'd0);
        chk("midreset_err", 32'(err_cnt - e0), 32'd0);
        chk("midreset_wr_addr", 32'(wr_addr), 32'd0);
        do_frame(32'h0001, 16);

        // Back-to-back frames with a two-clock chip-select gap.
        v0 = vld_cnt;
        e0 = err_cnt;
        frame(32'h0010, 16, 2);
        frame(32'h0411, 16, 12);
        model[0] = 9'h010;
        model[2] = 9'h011;
        chk("b2b_vld", 32'(vld_cnt - v0), 32'd2);
        chk("b2b_err", 32'(err_cnt - e0), 32'd0);
        chk("b2b_wr_addr", 32'(wr_addr), 32'd2);
        check_regs();

        for (int k = 0; k < 24; k++) begin
            n = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(14, 18);
            bits = $urandom;
            if (n == 16) bits = {16'd0, 7'($urandom_range(0, 23)), 9'($urandom_range(0, 511))};
            do_frame(bits, n);
        end

`ifdef SPI_READBACK_EN
        do_frame(32'h0355, 16);
        do_frame(32'hFE00, 16);
        chk("readback", 32'(rx_word), 32'({7'd1, model[1]}));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
